// File: rtl/bitmap_pkg.sv
// Shared bitmap memory geometry and scanner FSM encoding.
// Geometry defaults are also used by the decryption engine that fills the memory.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package bitmap_pkg;

  localparam int unsigned BITMAP_MEM_WIDTH     = 128;
  localparam int unsigned MAX_BITMAP_MEM_DEPTH = 2048;

  localparam int unsigned AW = `CLOG2(MAX_BITMAP_MEM_DEPTH);
  localparam int unsigned BW = `CLOG2(BITMAP_MEM_WIDTH);
  localparam int unsigned IW = AW + BW;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StLoad  = 3'd2,
    StScan  = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit finder; pos is 0 when vec is all zeros.
module lsb_priority_encoder #(
  parameter int unsigned Width = 128,
  localparam int unsigned PosW = $clog2(Width)
) (
  input  logic [Width-1:0] vec,
  output logic [PosW-1:0]  pos,
  output logic             any
);

  always_comb begin
    pos = '0;
    // Walk downward so the lowest set bit is the last one assigned.
    for (int i = Width - 1; i >= 0; i--) begin
      if (vec[i]) begin
        pos = PosW'(i);
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/bitmap_index_scanner.sv
// Walks a bitmap memory word by word and streams the global index of every set bit,
// lowest index first, on a valid/ready interface.
module bitmap_index_scanner #(
  parameter int unsigned BITMAP_MEM_WIDTH     = bitmap_pkg::BITMAP_MEM_WIDTH,
  parameter int unsigned MAX_BITMAP_MEM_DEPTH = bitmap_pkg::MAX_BITMAP_MEM_DEPTH,
  localparam int unsigned AddrW = $clog2(MAX_BITMAP_MEM_DEPTH),
  localparam int unsigned BitW  = $clog2(BITMAP_MEM_WIDTH),
  localparam int unsigned IdxW  = AddrW + BitW
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [AddrW-1:0]            bit_map_depth,
  output logic [AddrW-1:0]            rd_addr,
  input  logic [BITMAP_MEM_WIDTH-1:0] rd_data,
  output logic [IdxW-1:0]             idx,
  output logic                        idx_valid,
  input  logic                        idx_ready,
  output logic                        busy,
  output logic                        done,
  output logic [IdxW:0]               set_count
);

  import bitmap_pkg::*;

  state_e                      state_q, state_d;
  logic [AddrW-1:0]            depth_q, depth_d;
  logic [AddrW-1:0]            word_addr_q, word_addr_d;
  logic [AddrW-1:0]            rd_addr_q, rd_addr_d;
  logic [BITMAP_MEM_WIDTH-1:0] word_q, word_d;
  logic [IdxW:0]               set_count_q, set_count_d;

  logic [BitW-1:0] lsb_pos;
  logic            lsb_any;
  logic            last_word;
  logic            last_bit;
  logic            advance;

  lsb_priority_encoder #(
    .Width (BITMAP_MEM_WIDTH)
  ) u_lsb_enc (
    .vec (word_q),
    .pos (lsb_pos),
    .any (lsb_any)
  );

  assign last_word = (word_addr_q == depth_q - AddrW'(1));
  // Clearing the lowest set bit leaves zero exactly when it was the only one.
  assign last_bit  = ~|(word_q & (word_q - BITMAP_MEM_WIDTH'(1)));

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    word_addr_d = word_addr_q;
    rd_addr_d   = rd_addr_q;
    word_d      = word_q;
    set_count_d = set_count_q;
    advance     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          depth_d     = bit_map_depth;
          set_count_d = '0;
          word_addr_d = '0;
          if (bit_map_depth == '0) begin
            state_d = StDone;
          end else begin
            rd_addr_d = '0;
            state_d   = StFetch;
          end
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        word_d = rd_data;
        if (rd_data == '0) begin
          advance = 1'b1;
        end else begin
          state_d = StScan;
        end
      end
      StScan: begin
        if (idx_ready) begin
          word_d      = word_q & ~(BITMAP_MEM_WIDTH'(1) << lsb_pos);
          set_count_d = set_count_q + 1'b1;
          advance     = last_bit;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (last_word) begin
        state_d = StDone;
      end else begin
        word_addr_d = word_addr_q + AddrW'(1);
        rd_addr_d   = word_addr_q + AddrW'(1);
        state_d     = StFetch;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      depth_q     <= '0;
      word_addr_q <= '0;
      rd_addr_q   <= '0;
      word_q      <= '0;
      set_count_q <= '0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      word_addr_q <= word_addr_d;
      rd_addr_q   <= rd_addr_d;
      word_q      <= word_d;
      set_count_q <= set_count_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign idx       = {word_addr_q, lsb_pos};
  assign idx_valid = (state_q == StScan) && lsb_any;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign set_count = set_count_q;

endmodule

// File: tb/tb_bitmap_index_scanner.sv
// Scoreboard bench: stimulus pushes expected indices, a negedge monitor pops and compares.
module tb_bitmap_index_scanner;

  localparam int unsigned W  = 128;
  localparam int unsigned D  = 2048;
  localparam int unsigned AW = 11;
  localparam int unsigned IW = 18;

  logic              clock;
  logic              reset;
  logic              start;
  logic [AW-1:0]     bit_map_depth;
  logic [AW-1:0]     rd_addr;
  logic [W-1:0]      rd_data;
  logic [IW-1:0]     idx;
  logic              idx_valid;
  logic              idx_ready;
  logic              busy;
  logic              done;
  logic [IW:0]       set_count;

  logic [W-1:0]      mem [D];
  logic [IW-1:0]     exp_q [$];
  int                n_checks = 0;
  int                n_errors = 0;
  int                done_cnt = 0;
  logic              stall_prev = 1'b0;
  logic [IW-1:0]     held_idx = '0;

  bitmap_index_scanner #(
    .BITMAP_MEM_WIDTH     (W),
    .MAX_BITMAP_MEM_DEPTH (D)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .bit_map_depth (bit_map_depth),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .idx           (idx),
    .idx_valid     (idx_valid),
    .idx_ready     (idx_ready),
    .busy          (busy),
    .done          (done),
    .set_count     (set_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered-read memory port
  always @(posedge clock) rd_data <= mem[rd_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("bp_hold_valid", 64'(idx_valid), 64'd1);
        check("bp_hold_idx", 64'(idx), 64'(held_idx));
      end
      stall_prev = idx_valid && !idx_ready;
      held_idx   = idx;
      if (done) done_cnt++;
      if (idx_valid && idx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_idx: got %0d expected none", idx);
        end else begin
          check("idx_order", 64'(idx), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Returns in cycle 1 relative to the edge that samples start.
  task automatic pulse_start(input logic [AW-1:0] depth);
    start         = 1'b1;
    bit_map_depth = depth;
    tick();
    start         = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < D; i++) mem[i] = '0;
  endtask

  task automatic load_order_image();
    clear_mem();
    mem[2] = '0;
    mem[2][0] = 1'b1;
    mem[2][127] = 1'b1;
    mem[3] = '0;
    mem[3][5] = 1'b1;
  endtask

  task automatic push_order();
    exp_q.push_back(IW'(256));
    exp_q.push_back(IW'(383));
    exp_q.push_back(IW'(389));
  endtask

  int d0;
  int n;

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    bit_map_depth = '0;
    idx_ready     = 1'b1;
    clear_mem();
    #23;
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_idx", 64'(idx), 64'd0);
    check("rst_idx_valid", 64'(idx_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_set_count", 64'(set_count), 64'd0);
    reset = 1'b1;
    tick();

    // Empty depth: done in cycle 1
    d0 = done_cnt;
    pulse_start('0);
    check("empty_done_c1", 64'(done), 64'd1);
    check("empty_idx_valid", 64'(idx_valid), 64'd0);
    tick();
    check("empty_done_drop", 64'(done), 64'd0);
    check("empty_busy_drop", 64'(busy), 64'd0);
    check("empty_set_count", 64'(set_count), 64'd0);
    check("empty_done_once", 64'(done_cnt - d0), 64'd1);

    // Single bit with cycle-accurate latency
    mem[0] = W'(1);
    exp_q.push_back(IW'(0));
    d0 = done_cnt;
    pulse_start(AW'(1));
    check("single_busy_c1", 64'(busy), 64'd1);
    check("single_rd_addr_c1", 64'(rd_addr), 64'd0);
    tick();
    check("single_valid_c2", 64'(idx_valid), 64'd0);
    tick();
    check("single_valid_c3", 64'(idx_valid), 64'd1);
    tick();
    check("single_done_c4", 64'(done), 64'd1);
    tick();
    check("single_set_count", 64'(set_count), 64'd1);
    check("single_drained", 64'(exp_q.size()), 64'd0);
    check("single_done_once", 64'(done_cnt - d0), 64'd1);

    // Multi-word ordering
    load_order_image();
    push_order();
    pulse_start(AW'(4));
    wait_done(100, "order_done");
    tick();
    check("order_set_count", 64'(set_count), 64'd3);
    check("order_last_rd_addr", 64'(rd_addr), 64'd3);
    check("order_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure on idx 383 for five cycles
    push_order();
    pulse_start(AW'(4));
    n = 0;
    while (!(idx_valid && idx == IW'(383)) && n < 100) begin
      tick();
      n++;
    end
    check("bp_reached_383", 64'(idx), 64'd383);
    idx_ready = 1'b0;
    repeat (5) tick();
    idx_ready = 1'b1;
    wait_done(100, "bp_done");
    tick();
    check("bp_set_count", 64'(set_count), 64'd3);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // start re-pulsed during SCAN is ignored
    push_order();
    pulse_start(AW'(4));
    n = 0;
    while (!idx_valid && n < 100) begin
      tick();
      n++;
    end
    pulse_start(AW'(1));
    wait_done(100, "restart_ignored_done");
    tick();
    check("restart_set_count", 64'(set_count), 64'd3);
    check("restart_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset during SCAN
    push_order();
    pulse_start(AW'(4));
    n = 0;
    while (!idx_valid && n < 100) begin
      tick();
      n++;
    end
    #2;
    reset = 1'b0;
    #1;
    check("arst_rd_addr", 64'(rd_addr), 64'd0);
    check("arst_idx", 64'(idx), 64'd0);
    check("arst_idx_valid", 64'(idx_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_set_count", 64'(set_count), 64'd0);
    exp_q.delete();
    tick();
    #2;
    reset = 1'b1;
    tick();

    // Rescan from word 0 after reset
    push_order();
    d0 = done_cnt;
    pulse_start(AW'(4));
    wait_done(100, "rescan_done");
    tick();
    check("rescan_set_count", 64'(set_count), 64'd3);
    check("rescan_drained", 64'(exp_q.size()), 64'd0);
    check("rescan_done_once", 64'(done_cnt - d0), 64'd1);

    // Largest representable depth with the last word all ones
    clear_mem();
    mem[D-2] = '1;
    for (int i = 0; i < 128; i++) exp_q.push_back(IW'((D - 2) * W + i));
    d0 = done_cnt;
    pulse_start(AW'(D - 1));
    wait_done(6000, "full_done");
    tick();
    tick();
    check("full_set_count", 64'(set_count), 64'd128);
    check("full_last_rd_addr", 64'(rd_addr), 64'(D - 2));
    check("full_drained", 64'(exp_q.size()), 64'd0);
    check("full_done_once", 64'(done_cnt - d0), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
